// File: rtl/multicycle_muldiv.sv
// Iterative integer multiply/divide unit (signed/unsigned mul, signed/unsigned div).
// Latency: start accepted at edge T, ready_o pulses in cycle T+WIDTH+1 (T+1 on zero shortcut).
// Backpressure: none queued; start_i is ignored while busy_o or ready cycle, annul_i aborts.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i, op_i   launch request; op 00 mul, 01 mulu, 10 div, 11 divu
//   a_i, b_i        multiplicand/dividend, multiplier/divisor (WIDTH bits)
//   annul_i         abort the operation in flight (pipeline flush)
//   busy_o          high while iterating (EX stall source)
//   ready_o         one-cycle result-valid pulse
//   hi_o, lo_o      product high/low half, or remainder/quotient
//   div_zero_o      last completed operation was a divide by zero
// Build option: define MULDIV_ZERO_SKIP_EN to finish zero-operand operations in one cycle.

module multicycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_bz;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dz;

    logic               w_busy;
    logic               w_ready;
    logic               w_skip;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_a_orig;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic               w_dz;

    // Signed ops (op[0]=0) work on magnitudes; signs are re-applied at completion.
    assign w_a_neg = ~op_i[0] & a_i[WIDTH-1];
    assign w_b_neg = ~op_i[0] & b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a_i + 1'b1) : a_i;
    assign w_b_mag = w_b_neg ? (~b_i + 1'b1) : b_i;

`ifdef MULDIV_ZERO_SKIP_EN
    assign w_skip = op_i[1] ? (b_i == '0) : ((a_i == '0) || (b_i == '0));
`else
    assign w_skip = 1'b0;
`endif

    // Multiply step: r_mq holds the remaining multiplier bits, r_acc the running high half.
    assign w_mul_sum  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mag_b} : '0);
    // Divide step: shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_div_sh   = {r_acc, r_mq[WIDTH-1]};
    assign w_div_ok   = (w_div_sh >= {1'b0, r_mag_b});
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_mag_b;

    assign w_prod   = {r_acc, r_mq};
    assign w_prod_s = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = (r_sa ^ r_sb) ? (~r_mq + 1'b1) : r_mq;
    assign w_rem    = r_sa ? (~r_acc + 1'b1) : r_acc;
    assign w_a_orig = r_sa ? (~r_mag_a + 1'b1) : r_mag_a;

    // Final result from the iteration registers; divide-by-zero overrides the datapath.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        w_dz = 1'b0;
        if (r_op[1]) begin
            if (r_bz) begin
                w_hi = w_a_orig;
                w_lo = '1;
                w_dz = 1'b1;
            end else begin
                w_hi = w_rem;
                w_lo = w_quo;
            end
        end else begin
            {w_hi, w_lo} = w_prod_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    w_next = w_skip ? DONE : RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (annul_i) begin
                    w_next = IDLE;
                end else if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                // An annul arriving in the result cycle cancels the pulse and the commit.
                w_ready = !annul_i;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bz    <= 1'b0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        r_op    <= op_i;
                        r_sa    <= w_a_neg;
                        r_sb    <= w_b_neg;
                        r_bz    <= (b_i == '0);
                        r_mag_a <= w_a_mag;
                        r_mag_b <= w_b_mag;
                        r_acc   <= '0;
                        // A skipped multiply must read back as a zero product.
                        r_mq    <= (w_skip && !op_i[1]) ? '0 : w_a_mag;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!annul_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op[1]) begin
                            r_acc <= w_div_ok ? w_div_diff : w_div_sh[WIDTH-1:0];
                            r_mq  <= {r_mq[WIDTH-2:0], w_div_ok};
                        end else begin
                            r_acc <= w_mul_sum[WIDTH:1];
                            r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
                        end
                    end
                end
                DONE: begin
                    if (!annul_i) begin
                        r_hi <= w_hi;
                        r_lo <= w_lo;
                        r_dz <= w_dz;
                    end
                end
                default: ;
            endcase
        end
    end

    // Results are visible in the ready cycle itself, then held from the registers.
    assign busy_o     = w_busy;
    assign ready_o    = w_ready;
    assign hi_o       = w_ready ? w_hi : r_hi;
    assign lo_o       = w_ready ? w_lo : r_lo;
    assign div_zero_o = w_ready ? w_dz : r_dz;

endmodule
